jtag_tap_controller: RTL and testbench

Single-clock IEEE 1149.1 TAP controller with a 2-bit instruction register and bypass cell. It sits directly upstream of the boundary scan register and drives that register's `shiftDR`, `clockDR`, `updateDR` and `mode` controls. It receives the register's `scan_out` and muxes it onto `TDO`. All control strobes are TCK-synchronous enables, not derived clocks; the boundary scan register samples them on the rising edge of `TCK`.

---
 rtl/jtag_pkg.sv | 31 +++
 rtl/jtag_tap_fsm.sv | 44 ++++
 rtl/jtag_tap_controller.sv | 114 +++++++++++
 tb/tb_jtag_tap_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP constants: 4-bit state encodings, 2-bit opcodes and the default device ID.
package jtag_pkg;

    localparam logic [3:0] ST_TLR   = 4'hF;
    localparam logic [3:0] ST_RTI   = 4'hC;
    localparam logic [3:0] ST_SELDR = 4'h7;
    localparam logic [3:0] ST_CAPDR = 4'h6;
    localparam logic [3:0] ST_SHDR  = 4'h2;
    localparam logic [3:0] ST_EX1DR = 4'h1;
    localparam logic [3:0] ST_PAUDR = 4'h3;
    localparam logic [3:0] ST_EX2DR = 4'h0;
    localparam logic [3:0] ST_UPDDR = 4'h5;
    localparam logic [3:0] ST_SELIR = 4'h4;
    localparam logic [3:0] ST_CAPIR = 4'hE;
    localparam logic [3:0] ST_SHIR  = 4'hA;
    localparam logic [3:0] ST_EX1IR = 4'h9;
    localparam logic [3:0] ST_PAUIR = 4'hB;
    localparam logic [3:0] ST_EX2IR = 4'h8;
    localparam logic [3:0] ST_UPDIR = 4'hD;

    localparam logic [1:0] OP_EXTEST = 2'b00;
    localparam logic [1:0] OP_SAMPLE = 2'b01;
    localparam logic [1:0] OP_IDCODE = 2'b10;
    localparam logic [1:0] OP_BYPASS = 2'b11;

    // Fixed pattern captured into the IR chain so a host can sanity-check the scan path.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    localparam logic [31:0] IDCODE_DEFAULT = 32'h0000_0001;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine; state register resets asynchronously to Test-Logic-Reset.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_rst,
    input  logic       i_tms,
    output logic [3:0] o_state
);

    logic [3:0] r_state;
    logic [3:0] w_next;

    always_comb begin
        w_next = ST_TLR;
        case (r_state)
            ST_TLR:   w_next = i_tms ? ST_TLR   : ST_RTI;
            ST_RTI:   w_next = i_tms ? ST_SELDR : ST_RTI;
            ST_SELDR: w_next = i_tms ? ST_SELIR : ST_CAPDR;
            ST_CAPDR: w_next = i_tms ? ST_EX1DR : ST_SHDR;
            ST_SHDR:  w_next = i_tms ? ST_EX1DR : ST_SHDR;
            ST_EX1DR: w_next = i_tms ? ST_UPDDR : ST_PAUDR;
            ST_PAUDR: w_next = i_tms ? ST_EX2DR : ST_PAUDR;
            ST_EX2DR: w_next = i_tms ? ST_UPDDR : ST_SHDR;
            ST_UPDDR: w_next = i_tms ? ST_SELDR : ST_RTI;
            ST_SELIR: w_next = i_tms ? ST_TLR   : ST_CAPIR;
            ST_CAPIR: w_next = i_tms ? ST_EX1IR : ST_SHIR;
            ST_SHIR:  w_next = i_tms ? ST_EX1IR : ST_SHIR;
            ST_EX1IR: w_next = i_tms ? ST_UPDIR : ST_PAUIR;
            ST_PAUIR: w_next = i_tms ? ST_EX2IR : ST_PAUIR;
            ST_EX2IR: w_next = i_tms ? ST_UPDIR : ST_SHIR;
            ST_UPDIR: w_next = i_tms ? ST_SELDR : ST_RTI;
            default:  w_next = ST_TLR;
        endcase
    end

    always_ff @(posedge i_tck or posedge i_rst) begin
        if (i_rst) r_state <= ST_TLR;
        else       r_state <= w_next;
    end

    assign o_state = r_state;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller driving a boundary scan register; 2-bit IR, bypass cell, TDO mux.
// Define JTAG_IDCODE_EN to add the 32-bit ID chain and make IDCODE the reset instruction.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 2,
    parameter logic [31:0] IDCODE_VALUE = IDCODE_DEFAULT
) (
    input  logic       TCK,
    input  logic       reset,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       bsr_scan_out,
    output logic       bsr_scan_in,
    output logic       shiftDR,
    output logic       clockDR,
    output logic       updateDR,
    output logic       mode,
    output logic       TDO,
    output logic       tdo_en,
    output logic [3:0] tap_state
);

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(OP_IDCODE);
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(OP_BYPASS);
`endif

    logic [3:0]          w_state;
    logic [IR_WIDTH-1:0] r_ir_chain;
    logic [IR_WIDTH-1:0] r_ir;
    logic                r_bypass;
    logic                w_bsr_sel;
    logic                w_in_shdr;
    logic                w_in_shir;
    logic                w_tdo;

    jtag_tap_fsm u_fsm (
        .i_tck   (TCK),
        .i_rst   (reset),
        .i_tms   (TMS),
        .o_state (w_state)
    );

    assign w_in_shdr = (w_state == ST_SHDR);
    assign w_in_shir = (w_state == ST_SHIR);
    assign w_bsr_sel = (r_ir == IR_WIDTH'(OP_EXTEST)) || (r_ir == IR_WIDTH'(OP_SAMPLE));

    // The active instruction only moves on leaving UpdIR, so mode is stable across DR scans.
    always_ff @(posedge TCK or posedge reset) begin
        if (reset) begin
            r_ir_chain <= IR_WIDTH'(IR_CAPTURE);
            r_ir       <= IR_RESET;
        end else begin
            case (w_state)
                ST_TLR:   r_ir       <= IR_RESET;
                ST_CAPIR: r_ir_chain <= IR_WIDTH'(IR_CAPTURE);
                ST_SHIR:  r_ir_chain <= {TDI, r_ir_chain[IR_WIDTH-1:1]};
                ST_UPDIR: r_ir       <= r_ir_chain;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge TCK or posedge reset) begin
        if (reset)                    r_bypass <= 1'b0;
        else if (w_state == ST_CAPDR) r_bypass <= 1'b0;
        else if (w_in_shdr)           r_bypass <= TDI;
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] r_id;
    logic        w_id_sel;

    assign w_id_sel = (r_ir == IR_WIDTH'(OP_IDCODE));

    always_ff @(posedge TCK or posedge reset) begin
        if (reset)                                r_id <= IDCODE_VALUE;
        else if (w_id_sel && w_state == ST_CAPDR) r_id <= IDCODE_VALUE;
        else if (w_id_sel && w_in_shdr)           r_id <= {TDI, r_id[31:1]};
    end

    always_comb begin
        w_tdo = 1'b0;
        if (w_in_shir)      w_tdo = r_ir_chain[0];
        else if (w_in_shdr) begin
            if (w_bsr_sel)     w_tdo = bsr_scan_out;
            else if (w_id_sel) w_tdo = r_id[0];
            else               w_tdo = r_bypass;
        end
    end
`else
    logic w_unused_idcode;
    assign w_unused_idcode = IDCODE_VALUE[0];

    // Opcode 10 falls through to the bypass cell when no ID chain is built.
    always_comb begin
        w_tdo = 1'b0;
        if (w_in_shir)      w_tdo = r_ir_chain[0];
        else if (w_in_shdr) w_tdo = w_bsr_sel ? bsr_scan_out : r_bypass;
    end
`endif

    assign bsr_scan_in = TDI;
    assign shiftDR     = w_bsr_sel && w_in_shdr;
    assign clockDR     = w_bsr_sel && (w_in_shdr || w_state == ST_CAPDR);
    assign updateDR    = w_bsr_sel && (w_state == ST_UPDDR);
    assign mode        = (r_ir == IR_WIDTH'(OP_EXTEST));
    assign TDO         = w_tdo;
    assign tdo_en      = w_in_shdr || w_in_shir;
    assign tap_state   = w_state;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller; data outputs go through an expected-value queue.
module tb_jtag_tap_controller;
    import jtag_pkg::*;

    localparam logic [31:0] TB_ID = 32'h4BA0_0477;

    logic       TCK = 1'b0;
    logic       reset;
    logic       TMS;
    logic       TDI;
    logic       bsr_scan_out;
    logic       bsr_scan_in;
    logic       shiftDR;
    logic       clockDR;
    logic       updateDR;
    logic       mode;
    logic       TDO;
    logic       tdo_en;
    logic [3:0] tap_state;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_clk, n_shift, n_upd;
    logic [31:0] sb_q[$];

    jtag_tap_controller #(.IR_WIDTH(2), .IDCODE_VALUE(TB_ID)) dut (
        .TCK          (TCK),
        .reset        (reset),
        .TMS          (TMS),
        .TDI          (TDI),
        .bsr_scan_out (bsr_scan_out),
        .bsr_scan_in  (bsr_scan_in),
        .shiftDR      (shiftDR),
        .clockDR      (clockDR),
        .updateDR     (updateDR),
        .mode         (mode),
        .TDO          (TDO),
        .tdo_en       (tdo_en),
        .tap_state    (tap_state)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] got);
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %0h expected <none queued>", tag, got);
        end else begin
            chk(tag, got, sb_q.pop_front());
        end
    endtask

    // Drive away from the edge, clock once, settle 1 time unit past the edge.
    task automatic tck(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic count_strobes();
        n_clk   += int'(clockDR);
        n_shift += int'(shiftDR);
        n_upd   += int'(updateDR);
    endtask

    // RTI -> ShIR, shift op LSB-first, UpdIR -> RTI
    task automatic load_ir(input logic [1:0] op);
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        tck(0, op[0]); tck(1, op[1]); tck(1, 0); tck(0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] id;
        logic [3:0]  byp_bits;
        id       = TB_ID;
        byp_bits = 4'b1101; // sent index 0 first: 1,0,1,1
        reset = 1'b1; TMS = 1'b1; TDI = 1'b0; bsr_scan_out = 1'b0;
        @(posedge TCK); @(posedge TCK); #1;
        chk("rst_state",    tap_state, ST_TLR);
        chk("rst_shiftDR",  shiftDR,   0);
        chk("rst_clockDR",  clockDR,   0);
        chk("rst_updateDR", updateDR,  0);
        chk("rst_mode",     mode,      0);
        chk("rst_tdo",      TDO,       0);
        chk("rst_tdo_en",   tdo_en,    0);
        reset = 1'b0;
        tck(0, 0); chk("rti", tap_state, ST_RTI);

        // load EXTEST by hand, checking IR capture on TDO
        tck(1, 0); chk("seldr", tap_state, ST_SELDR);
        tck(1, 0); chk("selir", tap_state, ST_SELIR);
        tck(0, 0); chk("capir", tap_state, ST_CAPIR);
        tck(0, 0); chk("shir", tap_state, ST_SHIR);
        chk("shir_tdo_en", tdo_en, 1);
        chk("shir_tdo0", TDO, 1);
        tck(0, 0); chk("shir_tdo1", TDO, 0);
        tck(1, 0); chk("ex1ir", tap_state, ST_EX1IR);
        tck(1, 0); chk("updir", tap_state, ST_UPDIR);
        chk("mode_in_updir", mode, 0);
        tck(0, 0); chk("mode_after_updir", mode, 1);

        // EXTEST DR pass: mode steady, strobes follow the states
        tck(1, 0); tck(0, 0);
        chk("ext_capdr_clk", clockDR, 1); chk("ext_capdr_shift", shiftDR, 0);
        chk("ext_capdr_mode", mode, 1);
        tck(0, 0); chk("ext_shdr_shift", shiftDR, 1); chk("ext_shdr_mode", mode, 1);
        tck(1, 0); tck(1, 0);
        chk("ext_upd", updateDR, 1); chk("ext_upd_mode", mode, 1);
        tck(0, 0); chk("ext_rti_upd", updateDR, 0);

        // SAMPLE: CapDR + 8 ShDR cycles
        load_ir(OP_SAMPLE);
        chk("sample_mode", mode, 0);
        n_clk = 0; n_shift = 0; n_upd = 0;
        tck(1, 0); tck(0, 0); count_strobes();
        tck(0, 0);
        for (int i = 0; i < 8; i++) begin
            bsr_scan_out = 1'($urandom);
            TDI          = 1'($urandom);
            sb_q.push_back({31'd0, bsr_scan_out});
            #1;
            count_strobes();
            sb_pop("sample_tdo", {31'd0, TDO});
            chk("scan_in", bsr_scan_in, TDI);
            tck(i == 7, TDI);
        end
        count_strobes();
        tck(1, 0); count_strobes();
        tck(0, 0); count_strobes();
        chk("sample_clk_cnt", n_clk, 9);
        chk("sample_shift_cnt", n_shift, 8);
        chk("sample_upd_cnt", n_upd, 1);

        // BYPASS: one-cycle delay through the cell, no BSR strobes
        load_ir(OP_BYPASS);
        tck(1, 0); tck(0, 0);
        chk("byp_clk", clockDR, 0);
        tck(0, 0);
        sb_q.push_back(32'd0);
        for (int i = 0; i < 4; i++) begin
            sb_pop("byp_tdo", {31'd0, TDO});
            sb_q.push_back({31'd0, byp_bits[i]});
            chk("byp_upd", updateDR, 0);
            tck(i == 3, byp_bits[i]);
        end
        sb_q.delete();
        tck(1, 0); chk("byp_upddr", tap_state, ST_UPDDR);
        chk("byp_upd_in_upddr", updateDR, 0);
        tck(0, 0);

        // five TMS=1 from mid ShIR
        load_ir(OP_EXTEST);
        chk("ext2_mode", mode, 1);
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0); tck(0, 1);
        tck(1, 0); chk("esc1", tap_state, ST_EX1IR);
        tck(1, 0); chk("esc2", tap_state, ST_UPDIR);
        tck(1, 0); chk("esc3", tap_state, ST_SELDR);
        tck(1, 0); chk("esc4", tap_state, ST_SELIR);
        tck(1, 0); chk("esc5", tap_state, ST_TLR);
        chk("esc_mode", mode, 0);
        tck(0, 0); tck(1, 0); tck(0, 0);
        chk("esc_default_clk", clockDR, 0);
        tck(1, 0); tck(1, 0); tck(0, 0);

        // asynchronous reset from ShDR
        load_ir(OP_SAMPLE);
        tck(1, 0); tck(0, 0); tck(0, 0);
        chk("pre_rst_shift", shiftDR, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_state", tap_state, ST_TLR);
        chk("arst_shift", shiftDR, 0);
        chk("arst_clk", clockDR, 0);
        chk("arst_upd", updateDR, 0);
        chk("arst_tdo_en", tdo_en, 0);
        @(posedge TCK); #1;
        reset = 1'b0;
        tck(0, 0); tck(1, 0); tck(0, 0);
        chk("post_rst_clk", clockDR, 0);
        chk("post_rst_mode", mode, 0);
        tck(0, 0);
`ifdef JTAG_IDCODE_EN
        for (int i = 0; i < 32; i++) begin
            sb_q.push_back({31'd0, id[i]});
            sb_pop("idcode_tdo", {31'd0, TDO});
            tck(i == 31, 0);
        end
`else
        sb_q.push_back(32'd0);
        sb_pop("post_rst_byp_tdo", {31'd0, TDO});
        tck(0, 1);
        sb_q.push_back(32'd1);
        sb_pop("post_rst_byp_tdo2", {31'd0, TDO});
        if (id[0] !== 1'b1) $display("note: TB_ID bit 0 is not 1");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
